data_mem_ctrl: RTL and testbench

- Parametrised data-memory controller between the single-cycle core's load/store path and an external handshaked memory port.
- Replaces the fixed 256-word internal array with a wait-state-tolerant bridge.
- Adds byte/half/word access, sign/zero extension, read-modify-write for sub-word stores, core stall generation, misalignment detection and response timeout.

---
 rtl/data_mem_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: bridges the core load/store path to a handshaked
// external memory port with sub-word access, RMW stores, stall and timeout.
module data_mem_ctrl #(
    parameter int S       = 32,
    parameter int AW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] a,
    input  logic [S-1:0]  din,
    output logic [S-1:0]  dout,
    input  logic          mread,
    input  logic          mwrite,
    input  logic [1:0]    msize,
    input  logic          munsigned,
    output logic          stall,
    output logic          err,
    output logic [AW-1:0] memory_addr,
    output logic          memory_rden,
    output logic          memory_wren,
    input  logic [S-1:0]  memory_read_val,
    output logic [S-1:0]  memory_write_val,
    input  logic          memory_response
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        DONE
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [CW-1:0]  cnt_q;
    logic [1:0]     lane_q;
    logic [1:0]     size_q;
    logic           uns_q;
    logic           store_q;
    logic [S-1:0]   din_q;

    logic           req;
    logic           misaligned;
    logic           timeout_hit;
    logic           start;
    logic           bad;
    logic           abort;
    logic           cnt_clr;
    logic           ld_cap;
    logic           merge;
    logic [S-1:0]   load_val;
    logic [S-1:0]   merge_val;
    logic [7:0]     rb;
    logic [15:0]    rh;

    assign req = mread | mwrite;

    assign misaligned = (msize == 2'b01 && a[0]) ||
                        (msize[1] && a[1:0] != 2'b00);

    assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

    assign stall       = req && (state_q != DONE);
    assign memory_rden = (state_q == RD);
    assign memory_wren = (state_q == WR);

    // Pick the addressed lane from the read word and extend it to S bits.
    always_comb begin
        rb = memory_read_val[{lane_q, 3'b000} +: 8];
        rh = lane_q[1] ? memory_read_val[31:16] : memory_read_val[15:0];
        unique case (size_q)
            2'b00:   load_val = {{24{~uns_q & rb[7]}}, rb};
            2'b01:   load_val = {{16{~uns_q & rh[15]}}, rh};
            default: load_val = memory_read_val;
        endcase
    end

    // Overlay the stored byte/half onto the word fetched for read-modify-write.
    always_comb begin
        merge_val = memory_read_val;
        if (size_q == 2'b00) begin
            merge_val[{lane_q, 3'b000} +: 8] = din_q[7:0];
        end else begin
            merge_val[{lane_q[1], 4'b0000} +: 16] = din_q[15:0];
        end
    end

    // Next-state and per-cycle control strobes for the access sequence.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        bad     = 1'b0;
        abort   = 1'b0;
        cnt_clr = 1'b0;
        ld_cap  = 1'b0;
        merge   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (misaligned) begin
                        bad     = 1'b1;
                        state_d = DONE;
                    end else begin
                        start   = 1'b1;
                        cnt_clr = 1'b1;
                        state_d = (mwrite && msize[1]) ? WR : RD;
                    end
                end
            end
            RD: begin
                if (memory_response) begin
                    if (store_q) begin
                        merge   = 1'b1;
                        cnt_clr = 1'b1;
                        state_d = WR;
                    end else begin
                        ld_cap  = 1'b1;
                        state_d = DONE;
                    end
                end else if (timeout_hit) begin
                    abort   = 1'b1;
                    state_d = DONE;
                end
            end
            WR: begin
                if (memory_response) begin
                    state_d = DONE;
                end else if (timeout_hit) begin
                    abort   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Per-phase wait counter, restarted whenever a strobe phase begins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (cnt_clr) begin
            cnt_q <= '0;
        end else if (state_q == RD || state_q == WR) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Request capture and registered memory-side address/data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q           <= '0;
            size_q           <= '0;
            uns_q            <= 1'b0;
            store_q          <= 1'b0;
            din_q            <= '0;
            memory_addr      <= '0;
            memory_write_val <= '0;
        end else if (start) begin
            lane_q      <= a[1:0];
            size_q      <= msize;
            uns_q       <= munsigned;
            store_q     <= mwrite;
            din_q       <= din;
            memory_addr <= {a[AW-1:2], 2'b00};
            if (mwrite && msize[1]) begin
                memory_write_val <= din;
            end
        end else if (merge) begin
            memory_write_val <= merge_val;
        end
    end

    // Load result and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
            err  <= 1'b0;
        end else begin
            if (ld_cap) begin
                dout <= load_val;
            end
            if (bad || abort) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: directed transactions push expected
// completions; a monitor checks each DONE cycle against the queue head.
module tb_data_mem_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] din;
    logic [31:0] dout;
    logic        mread;
    logic        mwrite;
    logic [1:0]  msize;
    logic        munsigned;
    logic        stall;
    logic        err;
    logic [31:0] memory_addr;
    logic        memory_rden;
    logic        memory_wren;
    logic [31:0] memory_read_val;
    logic [31:0] memory_write_val;
    logic        memory_response;

    typedef struct {
        logic [31:0] dout;
        logic [31:0] addr;
        logic [31:0] wv;
        logic        err;
        int          st;
        int          rd;
        int          wr;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   rd_wait = 0;
    int   wr_wait = 0;

    data_mem_ctrl #(
        .S(32),
        .AW(32),
        .TIMEOUT(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .a(a),
        .din(din),
        .dout(dout),
        .mread(mread),
        .mwrite(mwrite),
        .msize(msize),
        .munsigned(munsigned),
        .stall(stall),
        .err(err),
        .memory_addr(memory_addr),
        .memory_rden(memory_rden),
        .memory_wren(memory_wren),
        .memory_read_val(memory_read_val),
        .memory_write_val(memory_write_val),
        .memory_response(memory_response)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Memory model: answers after rd_wait/wr_wait cycles of strobe (-1 = never).
    initial begin
        int  rsc;
        int  wsc;
        bit  prev_rd;
        bit  prev_wr;
        rsc = 0;
        wsc = 0;
        prev_rd = 0;
        prev_wr = 0;
        memory_response = 1'b0;
        forever begin
            @(negedge clk);
            if (memory_rden) begin
                rsc = prev_rd ? rsc + 1 : 0;
                memory_response = (rd_wait >= 0 && rsc == rd_wait);
            end else if (memory_wren) begin
                wsc = prev_wr ? wsc + 1 : 0;
                memory_response = (wr_wait >= 0 && wsc == wr_wait);
            end else begin
                memory_response = 1'b0;
            end
            prev_rd = memory_rden;
            prev_wr = memory_wren;
        end
    end

    // Monitor: counts stall/strobe cycles and checks each completion.
    initial begin
        int   sc;
        int   rc;
        int   wc;
        exp_t e;
        sc = 0;
        rc = 0;
        wc = 0;
        forever begin
            @(negedge clk);
            if (!(mread | mwrite)) begin
                sc = 0;
                rc = 0;
                wc = 0;
            end else begin
                if (stall) sc++;
                if (memory_rden) rc++;
                if (memory_wren) wc++;
                if (!stall) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done actual=1 required=0");
                    end else begin
                        e = exp_q.pop_front();
                        chk("dout", dout, e.dout);
                        chk("err", 32'(err), 32'(e.err));
                        chk("addr", memory_addr, e.addr);
                        chk("wval", memory_write_val, e.wv);
                        chk("stall_cycles", 32'(sc), 32'(e.st));
                        chk("rden_cycles", 32'(rc), 32'(e.rd));
                        chk("wren_cycles", 32'(wc), 32'(e.wr));
                        chk("strobes_in_done",
                            32'({memory_rden, memory_wren}), 32'd0);
                    end
                    sc = 0;
                    rc = 0;
                    wc = 0;
                end
            end
        end
    end

    task automatic txn(input logic r, input logic w, input logic [1:0] sz,
                       input logic u, input logic [31:0] addr,
                       input logic [31:0] d, input logic [31:0] rv,
                       input int rw, input int ww, input exp_t e);
        bit done;
        exp_q.push_back(e);
        @(posedge clk);
        #2;
        memory_read_val = rv;
        rd_wait = rw;
        wr_wait = ww;
        a = addr;
        din = d;
        msize = sz;
        munsigned = u;
        mread = r;
        mwrite = w;
        done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!stall) begin
                done = 1;
                break;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL txn_timeout actual=stalled required=done");
        end
        @(posedge clk);
        #2;
        mread = 1'b0;
        mwrite = 1'b0;
    endtask

    function automatic exp_t mk(input logic [31:0] dv, input logic [31:0] ad,
                                input logic [31:0] wv, input logic er,
                                input int st, input int rd, input int wr);
        exp_t e;
        e.dout = dv;
        e.addr = ad;
        e.wv = wv;
        e.err = er;
        e.st = st;
        e.rd = rd;
        e.wr = wr;
        return e;
    endfunction

    initial begin
        bit seen;
        rst_n = 1'b0;
        a = '0;
        din = '0;
        mread = 1'b0;
        mwrite = 1'b0;
        msize = 2'b10;
        munsigned = 1'b0;
        memory_read_val = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dout", dout, 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_strobes", 32'({memory_rden, memory_wren}), 32'h0);
        chk("rst_addr", memory_addr, 32'h0);
        chk("rst_wval", memory_write_val, 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        #1;
        rst_n = 1'b1;

        txn(1, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 2, 0,
            mk(32'hDEADBEEF, 32'h10, 32'h0, 0, 4, 3, 0));
        txn(1, 0, 2'b00, 0, 32'h23, 32'h0, 32'h80123456, 0, 0,
            mk(32'hFFFFFF80, 32'h20, 32'h0, 0, 2, 1, 0));
        txn(1, 0, 2'b00, 1, 32'h23, 32'h0, 32'h80123456, 0, 0,
            mk(32'h00000080, 32'h20, 32'h0, 0, 2, 1, 0));
        txn(1, 0, 2'b01, 0, 32'h22, 32'h0, 32'h80017FFF, 1, 0,
            mk(32'hFFFF8001, 32'h20, 32'h0, 0, 3, 2, 0));
        txn(0, 1, 2'b01, 0, 32'h42, 32'h0000BEEF, 32'h11223344, 0, 0,
            mk(32'hFFFF8001, 32'h40, 32'hBEEF3344, 0, 3, 1, 1));
        txn(0, 1, 2'b00, 0, 32'h01, 32'h000000AB, 32'h11223344, 0, 0,
            mk(32'hFFFF8001, 32'h0, 32'h1122AB44, 0, 3, 1, 1));
        txn(0, 1, 2'b10, 0, 32'h50, 32'hCAFEF00D, 32'h0, 0, 1,
            mk(32'hFFFF8001, 32'h50, 32'hCAFEF00D, 0, 3, 0, 2));
        txn(1, 0, 2'b11, 0, 32'h60, 32'h0, 32'h12345678, 0, 0,
            mk(32'h12345678, 32'h60, 32'hCAFEF00D, 0, 2, 1, 0));
        txn(1, 0, 2'b10, 0, 32'h06, 32'h0, 32'hFFFFFFFF, 0, 0,
            mk(32'h12345678, 32'h60, 32'hCAFEF00D, 1, 1, 0, 0));
        txn(0, 1, 2'b01, 0, 32'h43, 32'h1, 32'hFFFFFFFF, 0, 0,
            mk(32'h12345678, 32'h60, 32'hCAFEF00D, 1, 1, 0, 0));
        txn(1, 1, 2'b10, 0, 32'h70, 32'h1, 32'h0, 0, -1,
            mk(32'h12345678, 32'h70, 32'h1, 1, 5, 0, 4));

        @(posedge clk);
        #2;
        memory_read_val = 32'hAAAAAAAA;
        rd_wait = -1;
        a = 32'h80;
        msize = 2'b10;
        mread = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (memory_rden) begin
                seen = 1;
                break;
            end
        end
        chk("rd_started", 32'(seen), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rden", 32'(memory_rden), 32'h0);
        chk("mid_rst_dout", dout, 32'h0);
        chk("mid_rst_err", 32'(err), 32'h0);
        mread = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        txn(1, 0, 2'b10, 0, 32'h84, 32'h0, 32'h55AA55AA, 0, 0,
            mk(32'h55AA55AA, 32'h84, 32'h0, 0, 2, 1, 0));

        repeat (2) @(posedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
